cpu_trace_buffer: RTL and testbench



---
 rtl/cpu_trace_buffer_if.sv | 20 ++
 rtl/cpu_trace_buffer.sv | 103 ++++++++++
 tb/tb_cpu_trace_buffer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_trace_buffer_if.sv
// Drain-side handshake of the CPU trace buffer: a first-word fall-through
// record port with valid/ready flow control.
interface cpu_trace_buffer_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_dest;
    logic [31:0] out_data;
    logic [7:0]  out_seq;

    modport master (
        output out_valid, out_pc, out_dest, out_data, out_seq,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_pc, out_dest, out_data, out_seq,
        output out_ready
    );
endinterface

// File: rtl/cpu_trace_buffer.sv
// Captures architecturally visible register writes of the multicycle CPU as
// sequence-numbered trace records and queues them in a FWFT circular FIFO.
module cpu_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 trace_en,
    input  logic                 trace_clr,
    input  logic                 RegWrite,
    input  logic [4:0]           MuxRegDestOut,
    input  logic [31:0]          MuxRegDataOut,
    input  logic [31:0]          RegPCOut,
    input  logic [5:0]           estado,
    cpu_trace_buffer_if.master   outPort,
    output logic [AW:0]          count,
    output logic                 overflow,
    output logic [15:0]          drop_count
);

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [31:0] data;
        logic [7:0]  seq;
    } traceRecord_t;

    localparam logic [AW:0] fullCount = (AW+1)'(DEPTH);

    traceRecord_t mem [DEPTH];
    traceRecord_t newRec;
    traceRecord_t headRec;

    logic [AW-1:0] rdPtr;
    logic [AW-1:0] wrPtr;
    logic          prevWe;
    logic [5:0]    prevSt;
    logic [7:0]    seqNum;

    logic live;
    logic writeEvent;
    logic full;
    logic pop;
    logic push;
    logic drop;

    // A clear or reset edge swallows any coincident event or handshake.
    assign live       = reset && !trace_clr;
    // Held RegWrite yields one record per control state, not one per cycle.
    assign writeEvent = live && trace_en && RegWrite && (MuxRegDestOut != 5'd0)
                        && (!prevWe || (estado != prevSt));
    assign full       = (count == fullCount);
    assign pop        = live && outPort.out_valid && outPort.out_ready;
    assign push       = writeEvent && (!full || pop);
    assign drop       = writeEvent && full && !pop;

    assign newRec = '{pc: RegPCOut, dest: MuxRegDestOut, data: MuxRegDataOut, seq: seqNum};
    assign headRec = mem[rdPtr];

    assign outPort.out_valid = (count != '0);
    assign outPort.out_pc    = headRec.pc;
    assign outPort.out_dest  = headRec.dest;
    assign outPort.out_data  = headRec.data;
    assign outPort.out_seq   = headRec.seq;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset || trace_clr) begin
            rdPtr      <= '0;
            wrPtr      <= '0;
            count      <= '0;
            seqNum     <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            prevWe     <= 1'b0;
            prevSt     <= '0;
        end else begin
            prevWe <= RegWrite;
            prevSt <= estado;
            if (writeEvent) seqNum <= seqNum + 8'd1;
            if (push)       wrPtr  <= wrPtr + AW'(1);
            if (pop)        rdPtr  <= rdPtr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end
        end
    end

    // NOTE: record storage is deliberately not reset; only pointers and count
    // define which entries are meaningful, so stale contents are never seen.
    always_ff @(posedge clock) begin
        if (push) mem[wrPtr] <= newRec;
    end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer: directed scenarios with literal
// expectations plus randomized traffic compared each cycle against a queue model.
module tb_cpu_trace_buffer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        trEn;
    logic        trClr;
    logic        regWrite;
    logic [4:0]  dest;
    logic [31:0] data;
    logic [31:0] pc;
    logic [5:0]  st;
    logic [AW:0] count;
    logic        overflow;
    logic [15:0] dropCount;

    cpu_trace_buffer_if outIf ();

    cpu_trace_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clock         (clock),
        .reset         (reset),
        .trace_en      (trEn),
        .trace_clr     (trClr),
        .RegWrite      (regWrite),
        .MuxRegDestOut (dest),
        .MuxRegDataOut (data),
        .RegPCOut      (pc),
        .estado        (st),
        .outPort       (outIf.master),
        .count         (count),
        .overflow      (overflow),
        .drop_count    (dropCount)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [31:0] data;
        logic [7:0]  seq;
    } rec_t;

    rec_t  mq[$];
    int    mSeq;
    int    mDrops;
    bit    mOverflow;
    bit    mPrevWe;
    int    mPrevSt;
    bit    checkOn = 1'b0;

    int    nChecks = 0;
    int    nMiss   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nMiss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model advance from the inputs sampled at this edge.
    task automatic modelStep();
        bit ev;
        if (!reset || trClr) begin
            mq.delete();
            mSeq = 0; mDrops = 0; mOverflow = 0; mPrevWe = 0; mPrevSt = 0;
            return;
        end
        ev = trEn && regWrite && dest != 0 && (!mPrevWe || int'(st) != mPrevSt);
        if (mq.size() != 0 && outIf.out_ready) void'(mq.pop_front());
        if (ev) begin
            if (mq.size() < DEPTH) mq.push_back('{pc, dest, data, 8'(mSeq)});
            else begin
                mOverflow = 1;
                if (mDrops < 65535) mDrops++;
            end
            mSeq = (mSeq + 1) % 256;
        end
        mPrevWe = regWrite;
        mPrevSt = int'(st);
    endtask

    task automatic tick();
        @(posedge clock);
        modelStep();
        #1;
    endtask

    // Each call produces a fresh event by moving to a new control state.
    task automatic fire(input logic [4:0] d, input logic [31:0] v, input logic [31:0] p);
        regWrite = 1'b1; dest = d; data = v; pc = p; st = st + 6'd1;
        tick();
    endtask

    task automatic idle();
        regWrite = 1'b0;
        tick();
    endtask

    always @(negedge clock) begin
        if (checkOn) begin
            check("out_valid", 32'(outIf.out_valid), 32'(mq.size() != 0));
            check("count", 32'(count), 32'(mq.size()));
            check("overflow", 32'(overflow), 32'(mOverflow));
            check("drop_count", 32'(dropCount), 32'(mDrops));
            if (mq.size() != 0) begin
                check("out_pc", outIf.out_pc, mq[0].pc);
                check("out_dest", 32'(outIf.out_dest), 32'(mq[0].dest));
                check("out_data", outIf.out_data, mq[0].data);
                check("out_seq", 32'(outIf.out_seq), 32'(mq[0].seq));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    task automatic doReset();
        reset = 1'b0; regWrite = 1'b0;
        tick(); tick();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; trEn = 1'b1; trClr = 1'b0; regWrite = 1'b0;
        dest = '0; data = '0; pc = '0; st = 6'd3;
        outIf.out_ready = 1'b0;
        mq.delete(); mSeq = 0; mDrops = 0; mOverflow = 0; mPrevWe = 0; mPrevSt = 0;
        doReset();
        checkOn = 1'b1;
        check("reset count", 32'(count), 32'd0);
        check("reset valid", 32'(outIf.out_valid), 32'd0);

        // Single write held three cycles in one state.
        regWrite = 1'b1; dest = 5'd5; data = 32'hDEADBEEF; pc = 32'h10;
        repeat (3) tick();
        idle();
        check("single count", 32'(count), 32'd1);
        check("single seq", 32'(outIf.out_seq), 32'd0);
        check("single dest", 32'(outIf.out_dest), 32'd5);
        check("single data", outIf.out_data, 32'hDEADBEEF);
        check("single pc", outIf.out_pc, 32'h10);

        // Filtering: $0 writes and disabled capture.
        doReset();
        regWrite = 1'b1; dest = 5'd0; st = st + 6'd1; tick();
        idle();
        trEn = 1'b0; regWrite = 1'b1; dest = 5'd7; st = st + 6'd1; tick();
        idle();
        trEn = 1'b1;
        check("filter count", 32'(count), 32'd0);
        fire(5'd9, 32'h1234, 32'h20);
        idle();
        check("filter seq", 32'(outIf.out_seq), 32'd0);

        // Overflow: 18 events into 16 slots.
        doReset();
        for (int i = 0; i < 18; i++) fire(5'd1 + 5'(i % 30), 32'h100 + 32'(i), 32'h400 + 32'(4 * i));
        idle();
        check("ovf count", 32'(count), 32'd16);
        check("ovf flag", 32'(overflow), 32'd1);
        check("ovf drops", 32'(dropCount), 32'd2);
        outIf.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("ovf drain seq", 32'(outIf.out_seq), 32'(i));
            tick();
        end
        outIf.out_ready = 1'b0;
        fire(5'd3, 32'hABC, 32'h500);
        idle();
        check("ovf next seq", 32'(outIf.out_seq), 32'd18);

        // Full push+pop in the same cycle.
        for (int i = 0; i < 15; i++) fire(5'd4, 32'h200 + 32'(i), 32'h600 + 32'(i));
        idle();
        check("full count", 32'(count), 32'd16);
        outIf.out_ready = 1'b1;
        fire(5'd6, 32'hFEED, 32'h700);
        outIf.out_ready = 1'b0;
        idle();
        check("fullpp count", 32'(count), 32'd16);
        check("fullpp overflow", 32'(overflow), 32'd1);
        check("fullpp drops", 32'(dropCount), 32'd2);
        check("fullpp head", 32'(outIf.out_seq), 32'd19);
        outIf.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("fullpp drain seq", 32'(outIf.out_seq), 32'(19 + i));
            tick();
        end
        outIf.out_ready = 1'b0;

        // Clear mid-stream with a coincident event.
        for (int i = 0; i < 5; i++) fire(5'd8, 32'(i), 32'h800);
        trClr = 1'b1;
        fire(5'd8, 32'h55, 32'h900);
        trClr = 1'b0;
        idle();
        check("clr count", 32'(count), 32'd0);
        check("clr valid", 32'(outIf.out_valid), 32'd0);
        check("clr drops", 32'(dropCount), 32'd0);
        fire(5'd2, 32'h66, 32'hA00);
        idle();
        check("clr next seq", 32'(outIf.out_seq), 32'd0);

        // Sustained streaming through pointer and seq wrap.
        outIf.out_ready = 1'b1;
        for (int i = 0; i < 300; i++) fire(5'($urandom_range(1, 31)), $urandom, $urandom);
        idle(); idle();
        check("stream drops", 32'(dropCount), 32'd0);
        check("stream count", 32'(count), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            regWrite        = ($urandom_range(0, 3) != 0);
            dest            = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            data            = $urandom;
            pc              = $urandom;
            if ($urandom_range(0, 2) == 0) st = 6'($urandom);
            trEn            = ($urandom_range(0, 9) != 0);
            trClr           = ($urandom_range(0, 199) == 0);
            outIf.out_ready = ($urandom_range(0, 3) == 0);
            tick();
        end
        trClr = 1'b0; regWrite = 1'b0;
        tick();

        checkOn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nMiss);
        $finish;
    end

endmodule
